// File: rtl/skid_fifo_pkg.sv
// Shared sizing helpers and control bundle for the skid_fifo elastic buffer.
package skid_fifo_pkg;

  // Ring holds depth-1 words; a single-entry ring still needs a 1-bit pointer.
  function automatic int ptr_width(input int depth);
    return (depth > 2) ? $clog2(depth - 1) : 1;
  endfunction

  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic bit is_pow2(input int v);
    return (v >= 2) && ((v & (v - 1)) == 0);
  endfunction

  function automatic bit params_ok(input int depth, input int almost_full_level);
    return is_pow2(depth) && (almost_full_level >= 1) && (almost_full_level <= depth);
  endfunction

  typedef struct packed {
    logic insert;
    logic remove;
    logic load_out;
    logic bypass;
  } ctl_t;

endpackage

// File: rtl/skid_fifo_ring.sv
// (DEPTH-1)-entry circular store behind the output register; pointers wrap at DEPTH-1.
module skid_fifo_ring
  import skid_fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty
);

  localparam int ENTRIES = DEPTH - 1;
  localparam int PW      = ptr_width(DEPTH);
  localparam int LW      = $clog2(ENTRIES + 1);

  logic [WIDTH-1:0] mem_q [ENTRIES];
  logic [WIDTH-1:0] mem_d [ENTRIES];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(ENTRIES - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = wr_data;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
      level_d = level_q + LW'(push) - LW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage words carry no reset; validity is tracked by level_q.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign empty   = (level_q == '0);

endmodule

// File: rtl/skid_fifo.sv
// Elastic valid/ready buffer: registered output word plus ring; all interface flags registered.
module skid_fifo
  import skid_fifo_pkg::*;
#(
  parameter int WORD_WIDTH        = 8,
  parameter int DEPTH             = 4,
  parameter int ALMOST_FULL_LEVEL = DEPTH - 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush,
  input  logic                          i_valid,
  output logic                          i_ready,
  input  logic [WORD_WIDTH-1:0]         i_data,
  output logic                          o_valid,
  input  logic                          o_ready,
  output logic [WORD_WIDTH-1:0]         o_data,
  output logic [count_width(DEPTH)-1:0] o_count,
  output logic                          o_almost_full
);

  localparam int CW = count_width(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_LVL  = CW'(ALMOST_FULL_LEVEL);

  if (!params_ok(DEPTH, ALMOST_FULL_LEVEL)) begin : g_param_check
    $error("skid_fifo: DEPTH must be a power of two >= 2 and ALMOST_FULL_LEVEL in 1..DEPTH");
  end

  ctl_t                  ctl;
  logic                  ring_push, ring_pop, ring_empty;
  logic [WORD_WIDTH-1:0] ring_rd_data;

  logic                  i_ready_q, i_ready_d;
  logic                  o_valid_q, o_valid_d;
  logic [WORD_WIDTH-1:0] o_data_q, o_data_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  almost_full_q, almost_full_d;

  always_comb begin
    ctl.insert   = i_valid & i_ready_q;
    ctl.remove   = o_valid_q & o_ready;
    // Output register takes a new word when it is empty or its word is leaving with a successor available.
    ctl.load_out = (~o_valid_q & ctl.insert) | (ctl.remove & (~ring_empty | ctl.insert));
    ctl.bypass   = ring_empty;

    ring_push = ~flush & ctl.insert & ~(ctl.load_out & ring_empty);
    ring_pop  = ~flush & ctl.load_out & ~ring_empty;

    o_data_d = o_data_q;
    if (flush) begin
      count_d = '0;
    end else begin
      count_d = count_q + CW'(ctl.insert) - CW'(ctl.remove);
      if (ctl.load_out) o_data_d = ctl.bypass ? i_data : ring_rd_data;
    end

    i_ready_d     = (count_d != DEPTH_C);
    o_valid_d     = (count_d != '0);
    almost_full_d = (count_d >= AF_LVL);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      i_ready_q     <= 1'b1;
      o_valid_q     <= 1'b0;
      o_data_q      <= '0;
      count_q       <= '0;
      almost_full_q <= 1'b0;
    end else begin
      i_ready_q     <= i_ready_d;
      o_valid_q     <= o_valid_d;
      o_data_q      <= o_data_d;
      count_q       <= count_d;
      almost_full_q <= almost_full_d;
    end
  end

  skid_fifo_ring #(
    .WIDTH (WORD_WIDTH),
    .DEPTH (DEPTH)
  ) u_ring (
    .clk     (clk),
    .reset   (reset),
    .flush   (flush),
    .push    (ring_push),
    .pop     (ring_pop),
    .wr_data (i_data),
    .rd_data (ring_rd_data),
    .empty   (ring_empty)
  );

  assign i_ready       = i_ready_q;
  assign o_valid       = o_valid_q;
  assign o_data        = o_data_q;
  assign o_count       = count_q;
  assign o_almost_full = almost_full_q;

`ifdef FORMAL
  logic f_past_q;
  always_ff @(posedge clk) f_past_q <= 1'b1;

  always_comb begin
    if (f_past_q && !reset) begin
      assert (count_q == CW'(u_ring.level_q) + CW'(o_valid_q));
      assert (count_q <= DEPTH_C);
      assert (!(ring_pop && ring_empty));
    end
  end

  always_ff @(posedge clk) begin
    if (f_past_q && !$past(reset) && !$past(flush) && $past(o_valid_q && !o_ready)) begin
      assert (o_valid_q);
      assert (o_data_q == $past(o_data_q));
    end
  end

  cover property (@(posedge clk) disable iff (reset)
    count_q == DEPTH_C ##[1:$] count_q == '0 ##[1:$] count_q == DEPTH_C);
`endif

endmodule

// File: tb/tb_skid_fifo.sv
// Directed and random checks of skid_fifo against a queue model of the word stream.
module tb_skid_fifo;
  localparam int DEPTH = 4;
  localparam int W     = 8;
  localparam int AFL   = DEPTH - 1;

  logic         clk = 1'b0;
  logic         reset, flush, i_valid, o_ready;
  logic [W-1:0] i_data;
  logic         i_ready, o_valid, o_almost_full;
  logic [W-1:0] o_data;
  logic [2:0]   o_count;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] mq[$];

  always #5 clk = ~clk;

  skid_fifo #(.WORD_WIDTH(W), .DEPTH(DEPTH), .ALMOST_FULL_LEVEL(AFL)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .i_valid(i_valid), .i_ready(i_ready), .i_data(i_data),
    .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data),
    .o_count(o_count), .o_almost_full(o_almost_full)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("model_i_ready", i_ready, mq.size() != DEPTH);
    chk("model_o_valid", o_valid, mq.size() != 0);
    chk("model_count", o_count, mq.size());
    chk("model_almost_full", o_almost_full, mq.size() >= AFL);
    if (mq.size() != 0) chk("model_o_data", o_data, mq[0]);
  endtask

  // One clock: model decides transfers from its own occupancy, then compares after the edge.
  task automatic cycle();
    bit ins, rem;
    ins = i_valid && (mq.size() != DEPTH);
    rem = o_ready && (mq.size() != 0);
    @(posedge clk);
    if (reset || flush) mq.delete();
    else begin
      if (rem) void'(mq.pop_front());
      if (ins) mq.push_back(i_data);
    end
    @(negedge clk);
    check_model();
  endtask

  task automatic drain();
    i_valid = 1'b0;
    o_ready = 1'b1;
    for (int k = 0; k < 2 * DEPTH && mq.size() != 0; k++) cycle();
    chk("drain_empty", o_count, 0);
  endtask

  initial begin
    logic         stalled;
    logic [W-1:0] held;

    reset = 1'b1; flush = 1'b0; i_valid = 1'b0; o_ready = 1'b0; i_data = '0;
    cycle();
    chk("rst_i_ready", i_ready, 1);
    chk("rst_o_valid", o_valid, 0);
    chk("rst_o_data", o_data, 0);
    chk("rst_count", o_count, 0);
    chk("rst_almost_full", o_almost_full, 0);
    reset = 1'b0;
    cycle();

    // Fill with 1..4 while downstream stalls.
    for (int k = 1; k <= 4; k++) begin
      i_valid = 1'b1; i_data = W'(k);
      cycle();
      chk("fill_count", o_count, k);
      chk("fill_almost_full", o_almost_full, k >= 3);
      chk("fill_i_ready", i_ready, k != 4);
      chk("fill_head", o_data, 1);
    end

    // Drain in order.
    i_valid = 1'b0; o_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("drain_order", o_data, k + 1);
      cycle();
    end
    chk("drain_count", o_count, 0);
    chk("drain_o_valid", o_valid, 0);

    // Streaming: one word in, one word out per cycle.
    for (int k = 0; k < 20; k++) begin
      i_valid = 1'b1; o_ready = 1'b1; i_data = W'(k);
      cycle();
      chk("stream_count", o_count, 1);
      chk("stream_data", o_data, k);
    end
    drain();

    // Random traffic with occasional flush.
    for (int k = 0; k < 1000; k++) begin
      if (!(i_valid && mq.size() == DEPTH)) begin
        i_valid = 1'($urandom_range(0, 1));
        i_data  = W'($urandom);
      end
      o_ready = 1'($urandom_range(0, 1));
      flush   = ($urandom_range(0, 63) == 0);
      stalled = (mq.size() != 0) && !o_ready && !flush;
      held    = (mq.size() != 0) ? mq[0] : '0;
      cycle();
      if (stalled) begin
        chk("stall_valid", o_valid, 1);
        chk("stall_data", o_data, held);
      end
    end
    flush = 1'b0;
    drain();

    // Flush with a word presented on the same cycle.
    o_ready = 1'b0; i_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      i_data = W'(8'h10 + k);
      cycle();
    end
    chk("pre_flush_count", o_count, 3);
    flush = 1'b1; i_data = 8'hAA;
    cycle();
    flush = 1'b0;
    chk("flush_count", o_count, 0);
    chk("flush_o_valid", o_valid, 0);
    chk("flush_i_ready", i_ready, 1);
    chk("flush_almost_full", o_almost_full, 0);
    o_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      i_valid = (k < 3); i_data = W'(8'h20 + k);
      cycle();
      chk("no_aa_after_flush", o_valid && (o_data == 8'hAA), 0);
    end
    drain();

    // Reset while full.
    o_ready = 1'b0; i_valid = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      i_data = W'(8'h30 + k);
      cycle();
    end
    chk("full_i_ready", i_ready, 0);
    i_valid = 1'b0; reset = 1'b1;
    cycle();
    reset = 1'b0;
    chk("rst2_i_ready", i_ready, 1);
    chk("rst2_o_valid", o_valid, 0);
    chk("rst2_o_data", o_data, 0);
    chk("rst2_count", o_count, 0);
    chk("rst2_almost_full", o_almost_full, 0);
    cycle();
    i_valid = 1'b1; i_data = 8'h55;
    cycle();
    i_valid = 1'b0;
    chk("post_rst_o_valid", o_valid, 1);
    chk("post_rst_o_data", o_data, 8'h55);
    chk("post_rst_count", o_count, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
